// File: rtl/mem_arbiter_2p.sv
// mem_arbiter_2p
// Two-requester arbiter and command sequencer for a single-port synchronous
// SRAM macro (16 x 1024 by default). At most one command is accepted per cycle
// and registered onto the macro pins in the following cycle. In-flight reads
// are tracked with a tag shift pipe, and each result is returned to the port
// that issued it.
//
// Build option:
//   MEM_ARB_RR_EN  defined   -> round-robin on contention (last-grant pointer)
//                  undefined -> fixed priority, port 0 wins contention
//
// Parameters:
//   DATA_W      data width (must match macro)
//   ADDR_W      address width (must match macro)
//   MEM_RD_LAT  cycles from macro sampling edge to valid mem_rd_data (1..4)
//
// Ports:
//   clock, reset_n                     clock, async active-low reset
//   px_req/we/addr/wdata (x=0,1)       request side, held until px_gnt
//   px_gnt                             combinational grant
//   px_rvalid, px_rdata                read response (one-cycle pulse, held data)
//   mem_chip_en/wr_en/rd_en/addr/wr_data  registered macro command
//   mem_rd_data                        macro read data
module mem_arbiter_2p #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 10,
    parameter int MEM_RD_LAT = 1
) (
    input  logic              clock,
    input  logic              reset_n,

    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,

    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,

    output logic              mem_chip_en,
    output logic              mem_wr_en,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic [DATA_W-1:0] mem_rd_data
);

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
`ifdef MEM_ARB_RR_EN
    logic lg_q, lg_d;
`endif

    always_comb begin
        p0_gnt = 1'b0;
        p1_gnt = 1'b0;
        if (p0_req && p1_req) begin
`ifdef MEM_ARB_RR_EN
            // The port that did not win last time gets this one.
            p0_gnt = lg_q;
            p1_gnt = ~lg_q;
`else
            p0_gnt = 1'b1;
`endif
        end else begin
            p0_gnt = p0_req;
            p1_gnt = p1_req;
        end
    end

    logic              acc;
    logic              sel;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    assign acc       = (p0_req && p0_gnt) || (p1_req && p1_gnt);
    assign sel       = p1_gnt;
    assign sel_we    = sel ? p1_we    : p0_we;
    assign sel_addr  = sel ? p1_addr  : p0_addr;
    assign sel_wdata = sel ? p1_wdata : p0_wdata;

`ifdef MEM_ARB_RR_EN
    assign lg_d = acc ? sel : lg_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) lg_q <= 1'b0;
        else          lg_q <= lg_d;
    end
`endif

    // ------------------------------------------------------------------
    // Command register: idle cycles drive every pin to zero
    // ------------------------------------------------------------------
    logic              ce_q, ce_d;
    logic              wr_q, wr_d;
    logic              rd_q, rd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    always_comb begin
        ce_d    = acc;
        wr_d    = acc && sel_we;
        rd_d    = acc && !sel_we;
        addr_d  = acc ? sel_addr  : '0;
        wdata_d = acc ? sel_wdata : '0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ce_q    <= 1'b0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            ce_q    <= ce_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign mem_chip_en = ce_q;
    assign mem_wr_en   = wr_q;
    assign mem_rd_en   = rd_q;
    assign mem_addr    = addr_q;
    assign mem_wr_data = wdata_q;

    // ------------------------------------------------------------------
    // Read tag pipe. Stage 0 is the command cycle; stage MEM_RD_LAT is the
    // cycle in which mem_rd_data holds that read's result.
    // ------------------------------------------------------------------
    logic [MEM_RD_LAT:0] tag_vld_q, tag_vld_d;
    logic [MEM_RD_LAT:0] tag_port_q, tag_port_d;

    assign tag_vld_d  = {tag_vld_q[MEM_RD_LAT-1:0], rd_d};
    assign tag_port_d = {tag_port_q[MEM_RD_LAT-1:0], sel};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tag_vld_q  <= '0;
            tag_port_q <= '0;
        end else begin
            tag_vld_q  <= tag_vld_d;
            tag_port_q <= tag_port_d;
        end
    end

    // ------------------------------------------------------------------
    // Response capture
    // ------------------------------------------------------------------
    logic              rv0_q, rv0_d, rv1_q, rv1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

    always_comb begin
        rv0_d    = tag_vld_q[MEM_RD_LAT] && !tag_port_q[MEM_RD_LAT];
        rv1_d    = tag_vld_q[MEM_RD_LAT] &&  tag_port_q[MEM_RD_LAT];
        rdata0_d = rv0_d ? mem_rd_data : rdata0_q;
        rdata1_d = rv1_d ? mem_rd_data : rdata1_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rv0_q    <= 1'b0;
            rv1_q    <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            rv0_q    <= rv0_d;
            rv1_q    <= rv1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign p0_rvalid = rv0_q;
    assign p1_rvalid = rv1_q;
    assign p0_rdata  = rdata0_q;
    assign p1_rdata  = rdata1_q;

endmodule
